instr_buffer: RTL and testbench
===============================

// Module: instr_buffer
// PURPOSE
//  Dual-slot instruction FIFO between the IF2 stage and decode. Each cycle it accepts 0-2 fetched
//  instructions (PC, instr word, brtype/pc-predict, ecode) and presents up to 2 in program order to decode.
//  o_full drives the fetch-pipeline stall_full_instr input. flush_BR empties it.
// PARAMETERS
//  DEPTH   16  entries; power of 2, >=4
//  PTR_W   $clog2(DEPTH)  pointer width (derived, do not override)
// PORTS
//  clk               in   1   clock, all state on posedge
//  rstn              in   1   synchronous active-low reset
//  flush_BR          in   1   branch-mispredict flush; empties buffer
//  i_is_valid        in   2   [0]=slot1 valid, [1]=slot2 valid (already masked by IF2 stall/flush)
//  i_PC1/i_PC2       in   32  PCs of slot1/slot2
//  i_instr1/i_instr2 in   32  instruction words
//  i_brtype_pcpre_1/2 in  34  branch type + predicted PC per slot
//  i_ecode_1/2       in   8   exception code; bit7 = exception present
//  i_stall_dec       in   1   decode cannot accept this cycle
//  o_full            out  1   fewer than 2 free entries
//  o_valid           out  2   [0]=head entry valid, [1]=head+1 valid
//  o_PC1/o_PC2, o_instr1/o_instr2, o_brtype_pcpre_1/2, o_ecode_1/2  out  32/32/34/8  head / head+1 entry fields
// BEHAVIOUR
//  - Storage: DEPTH x 106-bit circular array; rd_ptr, wr_ptr (PTR_W, wrap modulo DEPTH), count (PTR_W+1).
//  - Reset (rstn=0 at posedge): rd_ptr=wr_ptr=count=0 -> o_valid=2'b00, o_full=0. Array not reset.
//  - o_full = (count > DEPTH-2), combinational from count.
//  - o_valid = {count>=2, count>=1}; outputs read head/head+1 combinationally (0-cycle read latency).
//  - Pop: n_pop = i_stall_dec ? 0 : popcount(o_valid); rd_ptr += n_pop. o_valid[1] never set without [0].
//  - Push (only when !o_full): pattern 11 writes slot1 at wr_ptr, slot2 at wr_ptr+1, n_push=2;
//    01 writes slot1, n_push=1; 10 writes slot2 at wr_ptr, n_push=1; 00 none.
//    Pushes while o_full are dropped (upstream is stalled by o_full, so none expected; assertion in TB).
//  - count_next = count + n_push - n_pop; push and pop in same cycle both take effect; pop uses
//    pre-push state (no same-cycle bypass: an instr pushed in cycle t is visible at o_* in t+1).
//  - Push into empty buffer with concurrent pop of nothing is legal; count never exceeds DEPTH.
//  - flush_BR=1: rd_ptr=wr_ptr=count=0 next cycle; same-cycle push and pop discarded. Flush beats push/pop.
//  - rstn=0 beats flush_BR. Reset mid-operation discards all contents.
//  - Entries with ecode[7]=1 are stored/forwarded unchanged; no special handling here.
//  - Pointers wrap silently; wr_ptr+1 computed modulo DEPTH.
// CONFIGURATION
//  IBUF_PERF_CNT_EN defined: adds output o_full_cycles [31:0]; reset to 0; increments (wrapping at 2^32)
//   every cycle o_full=1 and rstn=1; not cleared by flush_BR.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset: hold rstn=0 2 cycles -> o_valid=00, o_full=0; release, no push -> stays 00.
//  2 Push 11 (PC 0x1c000000/0x1c000004), i_stall_dec=1 -> next cycle o_valid=11, o_PC1=0x1c000000, o_PC2=0x1c000004.
//  3 i_stall_dec=1, push 11 x7 (DEPTH=16) -> count=14, o_full=0; one more push 11 -> count=16, o_full=1;
//    following push 11 dropped, count stays 16.
//  4 Pattern 10 with i_PC2=0x1c000104 into empty -> o_valid=01, o_PC1=0x1c000104.
//  5 Count=5, push 11 + pop 2 + flush_BR same cycle -> next cycle count=0, o_valid=00.
//  6 Continuous push 11/pop 2 for 20 cycles -> wrap-around; PCs out in exact push order, none lost/duplicated.

Source files
------------

// File: rtl/instr_buffer.sv
// -----------------------------------------------------------------------------
// instr_buffer
//   Dual-slot instruction FIFO between the IF2 fetch stage and decode. Each
//   cycle it accepts 0-2 fetched instructions and presents up to two, oldest
//   first, to decode. Each entry is {PC, instr, brtype/pc-predict, ecode}
//   (32+32+34+8 = 106 bits).
//
//   Optional feature: define IBUF_PERF_CNT_EN to add o_full_cycles, a wrapping
//   32-bit count of cycles spent with o_full asserted outside reset.
//
// Ports
//   clk, rstn            clock; synchronous active-low reset
//   flush_BR             branch-mispredict flush, empties the buffer
//   i_is_valid[1:0]      [0]=slot1 valid, [1]=slot2 valid
//   i_PC*/i_instr*/i_brtype_pcpre_*/i_ecode_*   incoming slot fields
//   i_stall_dec          decode cannot accept this cycle
//   o_full               fewer than 2 free entries (stalls fetch)
//   o_valid[1:0]         [0]=head valid, [1]=head+1 valid
//   o_PC*/o_instr*/o_brtype_pcpre_*/o_ecode_*   head / head+1 entry fields
//   o_full_cycles        (IBUF_PERF_CNT_EN only) full-cycle counter
//
// Handshake: an output entry is consumed on a cycle where its o_valid bit is
// set and i_stall_dec is low; decode always takes every valid entry at once.
// An input slot is accepted on a cycle where its i_is_valid bit is set and
// o_full is low; upstream is expected to hold off while o_full is high.
// -----------------------------------------------------------------------------
module instr_buffer #(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush_BR,
  input  logic [1:0]  i_is_valid,
  input  logic [31:0] i_PC1,
  input  logic [31:0] i_PC2,
  input  logic [31:0] i_instr1,
  input  logic [31:0] i_instr2,
  input  logic [33:0] i_brtype_pcpre_1,
  input  logic [33:0] i_brtype_pcpre_2,
  input  logic [7:0]  i_ecode_1,
  input  logic [7:0]  i_ecode_2,
  input  logic        i_stall_dec,
  output logic        o_full,
  output logic [1:0]  o_valid,
  output logic [31:0] o_PC1,
  output logic [31:0] o_PC2,
  output logic [31:0] o_instr1,
  output logic [31:0] o_instr2,
  output logic [33:0] o_brtype_pcpre_1,
  output logic [33:0] o_brtype_pcpre_2,
  output logic [7:0]  o_ecode_1,
  output logic [7:0]  o_ecode_2
`ifdef IBUF_PERF_CNT_EN
  ,
  output logic [31:0] o_full_cycles
`endif
);

  localparam int ENTRY_W = 106;
  localparam logic [PTR_W:0] FULL_THR = (PTR_W+1)'(DEPTH - 2);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_TWO  = (PTR_W+1)'(2);

  // Storage is deliberately not reset; o_valid masks stale contents.
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  logic [PTR_W-1:0]   rd_ptr_p1;
  logic [PTR_W-1:0]   wr_ptr_p1;
  logic               full;
  logic               valid_lo;
  logic               valid_hi;
  logic [1:0]         n_pop;
  logic [1:0]         n_push;
  logic               we0;
  logic               we1;
  logic [ENTRY_W-1:0] slot1_w;
  logic [ENTRY_W-1:0] slot2_w;
  logic [ENTRY_W-1:0] wdata0;

  assign slot1_w = {i_PC1, i_instr1, i_brtype_pcpre_1, i_ecode_1};
  assign slot2_w = {i_PC2, i_instr2, i_brtype_pcpre_2, i_ecode_2};

  always_comb begin
    rd_ptr_p1 = rd_ptr_q + PTR_W'(1);
    wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
    full      = (count_q > FULL_THR);
    valid_lo  = (count_q >= CNT_ONE);
    valid_hi  = (count_q >= CNT_TWO);

    // Pop is decided from pre-push occupancy: no same-cycle bypass.
    n_pop = 2'd0;
    if (!i_stall_dec) begin
      n_pop = valid_hi ? 2'd2 : (valid_lo ? 2'd1 : 2'd0);
    end

    // A lone slot (either slot1 or slot2) always lands at wr_ptr so the
    // stored order stays dense.
    n_push = 2'd0;
    we0    = 1'b0;
    we1    = 1'b0;
    wdata0 = i_is_valid[0] ? slot1_w : slot2_w;
    if (!full && !flush_BR) begin
      case (i_is_valid)
        2'b11: begin n_push = 2'd2; we0 = 1'b1; we1 = 1'b1; end
        2'b01,
        2'b10: begin n_push = 2'd1; we0 = 1'b1; end
        default: ;
      endcase
    end

    rd_ptr_d = rd_ptr_q + PTR_W'(n_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
    count_d  = count_q + (PTR_W+1)'(n_push) - (PTR_W+1)'(n_pop);

    // Flush wins over any concurrent push or pop.
    if (flush_BR) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && we0) mem_q[wr_ptr_q]  <= wdata0;
    if (rstn && we1) mem_q[wr_ptr_p1] <= slot2_w;
  end

  assign o_full  = full;
  assign o_valid = {valid_hi, valid_lo};
  assign {o_PC1, o_instr1, o_brtype_pcpre_1, o_ecode_1} = mem_q[rd_ptr_q];
  assign {o_PC2, o_instr2, o_brtype_pcpre_2, o_ecode_2} = mem_q[rd_ptr_p1];

`ifdef IBUF_PERF_CNT_EN
  logic [31:0] full_cycles_q, full_cycles_d;

  // Survives flush_BR; only reset clears it.
  always_comb begin
    full_cycles_d = full_cycles_q;
    if (full) full_cycles_d = full_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) full_cycles_q <= '0;
    else       full_cycles_q <= full_cycles_d;
  end

  assign o_full_cycles = full_cycles_q;
`endif

endmodule

// File: tb/tb_instr_buffer.sv
// -----------------------------------------------------------------------------
// tb_instr_buffer
//   Directed bench for instr_buffer (DEPTH=16). Inputs change 1 ns after the
//   rising edge; outputs are checked there as well, away from the edge.
// -----------------------------------------------------------------------------
module tb_instr_buffer;

  logic        clk;
  logic        rstn;
  logic        flush_BR;
  logic [1:0]  i_is_valid;
  logic [31:0] i_PC1, i_PC2, i_instr1, i_instr2;
  logic [33:0] i_brtype_pcpre_1, i_brtype_pcpre_2;
  logic [7:0]  i_ecode_1, i_ecode_2;
  logic        i_stall_dec;
  logic        o_full;
  logic [1:0]  o_valid;
  logic [31:0] o_PC1, o_PC2, o_instr1, o_instr2;
  logic [33:0] o_brtype_pcpre_1, o_brtype_pcpre_2;
  logic [7:0]  o_ecode_1, o_ecode_2;
`ifdef IBUF_PERF_CNT_EN
  logic [31:0] o_full_cycles;
`endif

  int errors = 0;
  int checks = 0;
  logic allow_full_push = 1'b0;
  logic [31:0] exp_q[$];

  instr_buffer #(.DEPTH(16)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .flush_BR         (flush_BR),
    .i_is_valid       (i_is_valid),
    .i_PC1            (i_PC1),
    .i_PC2            (i_PC2),
    .i_instr1         (i_instr1),
    .i_instr2         (i_instr2),
    .i_brtype_pcpre_1 (i_brtype_pcpre_1),
    .i_brtype_pcpre_2 (i_brtype_pcpre_2),
    .i_ecode_1        (i_ecode_1),
    .i_ecode_2        (i_ecode_2),
    .i_stall_dec      (i_stall_dec),
    .o_full           (o_full),
    .o_valid          (o_valid),
    .o_PC1            (o_PC1),
    .o_PC2            (o_PC2),
    .o_instr1         (o_instr1),
    .o_instr2         (o_instr2),
    .o_brtype_pcpre_1 (o_brtype_pcpre_1),
    .o_brtype_pcpre_2 (o_brtype_pcpre_2),
    .o_ecode_1        (o_ecode_1),
    .o_ecode_2        (o_ecode_2)
`ifdef IBUF_PERF_CNT_EN
    ,
    .o_full_cycles    (o_full_cycles)
`endif
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream must never offer instructions while the buffer reports full,
  // except where a step deliberately tests the drop behaviour.
  always @(negedge clk) begin
    if (rstn && o_full && (|i_is_valid) && !allow_full_push) begin
      errors++;
      $error("FAIL push_while_full observed valid=%b full=%b", i_is_valid, o_full);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] pc1, input logic [31:0] pc2,
                       input logic stall, input logic flush);
    i_is_valid       = v;
    i_PC1            = pc1;
    i_PC2            = pc2;
    i_instr1         = ~pc1;
    i_instr2         = ~pc2;
    i_brtype_pcpre_1 = {2'b01, pc1 + 32'h40};
    i_brtype_pcpre_2 = {2'b10, pc2 + 32'h40};
    i_ecode_1        = 8'h00;
    i_ecode_2        = {1'b1, pc2[6:0]};
    i_stall_dec      = stall;
    flush_BR         = flush;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset held for two cycles
    rstn = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    check("rst_valid", 64'(o_valid), 64'(2'b00));
    check("rst_full",  64'(o_full),  64'(1'b0));
`ifdef IBUF_PERF_CNT_EN
    check("rst_full_cycles", 64'(o_full_cycles), 64'd0);
`endif
    rstn = 1'b1;
    tick();
    check("idle_valid", 64'(o_valid), 64'(2'b00));

    // 2: push pair with decode stalled; visible only the next cycle
    drive(2'b11, 32'h1c000000, 32'h1c000004, 1'b1, 1'b0);
    #1;
    check("no_bypass_valid", 64'(o_valid), 64'(2'b00));
    exp_q.push_back(32'h1c000000);
    exp_q.push_back(32'h1c000004);
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    check("t2_valid",  64'(o_valid),          64'(2'b11));
    check("t2_pc1",    64'(o_PC1),            64'h1c000000);
    check("t2_pc2",    64'(o_PC2),            64'h1c000004);
    check("t2_instr1", 64'(o_instr1),         64'he3ffffff);
    check("t2_brt1",   64'(o_brtype_pcpre_1), 64'h11c000040);
    check("t2_ecode2", 64'(o_ecode_2),        64'h84);
    check("t2_full",   64'(o_full),           64'(1'b0));

    // 3: fill to 14, then 16, then a dropped push
    for (int i = 0; i < 6; i++) begin
      drive(2'b11, 32'h1c000008 + 32'(8*i), 32'h1c00000c + 32'(8*i), 1'b1, 1'b0);
      exp_q.push_back(32'h1c000008 + 32'(8*i));
      exp_q.push_back(32'h1c00000c + 32'(8*i));
      tick();
    end
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    check("cnt14_full", 64'(o_full), 64'(1'b0));
    drive(2'b11, 32'h1c000038, 32'h1c00003c, 1'b1, 1'b0);
    exp_q.push_back(32'h1c000038);
    exp_q.push_back(32'h1c00003c);
    tick();
    check("cnt16_full", 64'(o_full), 64'(1'b1));
    allow_full_push = 1'b1;
    drive(2'b11, 32'h2bad0000, 32'h2bad0004, 1'b1, 1'b0);
    tick();
    allow_full_push = 1'b0;
    check("drop_full", 64'(o_full), 64'(1'b1));
    // Drain: exactly the 16 accepted PCs in order, then empty
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      check("drain_valid", 64'(o_valid), 64'(2'b11));
      check("drain_pc1",   64'(o_PC1),   64'(exp_q[0]));
      check("drain_pc2",   64'(o_PC2),   64'(exp_q[1]));
      if (k == 1) check("drain_full_clear", 64'(o_full), 64'(1'b0));
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      tick();
    end
    check("drained_valid", 64'(o_valid), 64'(2'b00));
`ifdef IBUF_PERF_CNT_EN
    check("full_cycles_2", 64'(o_full_cycles), 64'd2);
`endif

    // 4: lone slot2 into empty buffer lands at head
    drive(2'b10, 32'hdeadbeef, 32'h1c000104, 1'b1, 1'b0);
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    check("t4_valid", 64'(o_valid), 64'(2'b01));
    check("t4_pc1",   64'(o_PC1),   64'h1c000104);
    tick();
    check("t4_popped", 64'(o_valid), 64'(2'b00));

    // 5: count=5, then push + pop + flush in one cycle
    drive(2'b11, 32'h1c000200, 32'h1c000204, 1'b1, 1'b0);
    tick();
    drive(2'b11, 32'h1c000208, 32'h1c00020c, 1'b1, 1'b0);
    tick();
    drive(2'b01, 32'h1c000210, 32'h0, 1'b1, 1'b0);
    tick();
    drive(2'b11, 32'h1c000214, 32'h1c000218, 1'b0, 1'b1);
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    check("flush_valid", 64'(o_valid), 64'(2'b00));
    check("flush_full",  64'(o_full),  64'(1'b0));
    tick();
    check("flush_stays", 64'(o_valid), 64'(2'b00));

    // Odd occupancy boundary: 15 entries already reports full
    for (int i = 0; i < 7; i++) begin
      drive(2'b11, 32'h1c000300 + 32'(8*i), 32'h1c000304 + 32'(8*i), 1'b1, 1'b0);
      tick();
    end
    drive(2'b01, 32'h1c000380, 32'h0, 1'b1, 1'b0);
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    check("cnt15_full", 64'(o_full), 64'(1'b1));

    // Reset mid-operation beats flush and a concurrent push
    rstn = 1'b0;
    allow_full_push = 1'b1;
    drive(2'b11, 32'h1c000400, 32'h1c000404, 1'b0, 1'b1);
    tick();
    allow_full_push = 1'b0;
    rstn = 1'b1;
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    check("midrst_valid", 64'(o_valid), 64'(2'b00));
    check("midrst_full",  64'(o_full),  64'(1'b0));
`ifdef IBUF_PERF_CNT_EN
    check("midrst_full_cycles", 64'(o_full_cycles), 64'd0);
`endif

    // 6: 20 cycles of push-2/pop-2, wrapping the 16-entry array
    for (int c = 0; c < 20; c++) begin
      drive(2'b11, 32'h1c001000 + 32'(8*c), 32'h1c001004 + 32'(8*c), 1'b0, 1'b0);
      exp_q.push_back(32'h1c001000 + 32'(8*c));
      exp_q.push_back(32'h1c001004 + 32'(8*c));
      tick();
      check("stream_valid", 64'(o_valid), 64'(2'b11));
      check("stream_pc1",   64'(o_PC1),   64'(exp_q[0]));
      check("stream_pc2",   64'(o_PC2),   64'(exp_q[1]));
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
    end
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    check("stream_end_valid", 64'(o_valid), 64'(2'b00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
